// File: rtl/audio_pdm_dac.sv
// audio_pdm_dac: final audio output stage. Offset-binary samples arrive over a
// valid/ready handshake into a one-entry pending register. They are promoted to
// the active sample on each oversampling tick. A first-order delta-sigma
// modulator turns the active sample into a 1-bit pulse-density stream.
// Optional feature: define AUDIO_PDM_DITHER_EN to add +/-1 LFSR dither in front
// of the modulator (clamped to the legal sample range).
module audio_pdm_dac #(
   parameter int BITDEPTH = 14,
   parameter int OSR      = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BITDEPTH-1:0] in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                pdm_out,
   output logic                underrun,
   output logic                tick
);

   localparam int                  CNT_W    = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(OSR - 1);
   localparam logic [BITDEPTH-1:0] MID      = {1'b1, {(BITDEPTH-1){1'b0}}};

   logic [CNT_W-1:0]    div_cnt;
   logic [BITDEPTH-1:0] pend;
   logic                pend_valid;
   logic [BITDEPTH-1:0] cur;
   logic [BITDEPTH-1:0] eff;
   logic [BITDEPTH-1:0] acc;
   logic [BITDEPTH:0]   sum;
   logic                xfer;

   // tick/underrun are decoded from registered state so they stay aligned
   assign tick     = (div_cnt == DIV_LAST);
   assign underrun = tick & ~pend_valid;
   // pending slot frees up on a tick, so a full slot can still accept then
   assign in_ready = ~pend_valid | tick;
   assign xfer     = in_valid & in_ready;

   // oversampling divider: 0..OSR-1, wraps on tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // pending register: a new transfer wins over the tick-time drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend       <= '0;
         pend_valid <= 1'b0;
      end else if (xfer) begin
         pend       <= in;
         pend_valid <= 1'b1;
      end else if (tick) begin
         pend_valid <= 1'b0;
      end
   end

   // active sample: promoted from pend on tick, otherwise held (underrun case)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= MID;
      end else if (tick && pend_valid) begin
         cur <= pend;
      end
   end

`ifdef AUDIO_PDM_DITHER_EN
   localparam logic [15:0]                 LFSR_TAPS = 16'hB400;
   localparam logic signed [BITDEPTH+1:0] STEP      = (BITDEPTH+2)'(1);
   localparam logic signed [BITDEPTH+1:0] MAXV      = $signed({2'b00, {BITDEPTH{1'b1}}});

   logic [15:0]                 lfsr;
   logic signed [BITDEPTH+1:0] eff_wide;

   // clamp a dithered sample back into [0, 2^BITDEPTH-1]
   function automatic logic [BITDEPTH-1:0] sat_sample(input logic signed [BITDEPTH+1:0] v);
      if (v < 0) begin
         return '0;
      end else if (v > MAXV) begin
         return '1;
      end else begin
         return v[BITDEPTH-1:0];
      end
   endfunction

   // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting, free running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   // +/-1 dither around the active sample, saturated at the rails
   always_comb begin
      eff_wide = $signed({2'b00, cur}) + (lfsr[0] ? STEP : -STEP);
      eff      = sat_sample(eff_wide);
   end
`else
   assign eff = cur;
`endif

   // first-order delta-sigma: carry out of the accumulator is the pulse
   assign sum = {1'b0, acc} + {1'b0, eff};

   // accumulator wraps naturally; carry is registered onto the pin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         pdm_out <= 1'b0;
      end else begin
         acc     <= sum[BITDEPTH-1:0];
         pdm_out <= sum[BITDEPTH];
      end
   end

endmodule

// File: tb/tb_audio_pdm_dac.sv
// tb_audio_pdm_dac: table-driven start-up vectors, hand-written corner
// sequences and a randomized run checked against a queue/total-based model.
module tb_audio_pdm_dac;

   localparam int BD   = 14;
   localparam int OSRP = 4;
   localparam int FULL = 16384;
   localparam int MID  = 8192;

   logic          clk = 1'b0;
   logic          rst;
   logic [BD-1:0] din;
   logic          in_valid;
   logic          in_ready;
   logic          pdm_out;
   logic          underrun;
   logic          tick;

   int n_cmp = 0;
   int n_bad = 0;

   audio_pdm_dac #(.BITDEPTH(BD), .OSR(OSRP)) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (din),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pdm_out  (pdm_out),
      .underrun (underrun),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 25)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Sample rate: a tick every OSR-th clock since reset. Pending slot: a queue.
   // Modulator: pulses are the carries of the running total of applied samples.
   longint m_total;
   longint m_cyc;
   longint m_prev;
   int     m_q[$];
   int     m_cur;
   bit     m_pdm;
   bit     m_t;
   bit     m_r;
   bit     chk_en = 1'b0;
   bit     c_et;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_total = 0;
         m_cyc   = 0;
         m_q.delete();
         m_cur   = MID;
         m_pdm   = 1'b0;
      end else begin
         m_t     = (m_cyc % OSRP) == OSRP - 1;
         m_r     = (m_q.size() == 0) || m_t;
         m_prev  = m_total;
         m_total = m_total + m_cur;
         m_pdm   = (m_total / FULL) != (m_prev / FULL);
         if (m_t && m_q.size() > 0) m_cur = m_q.pop_front();
         if (in_valid && m_r) m_q.push_back(int'(din));
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         c_et = (m_cyc % OSRP) == OSRP - 1;
         check("model_tick", int'(tick), int'(c_et));
         check("model_ready", int'(in_ready), int'((m_q.size() == 0) || c_et));
         check("model_underrun", int'(underrun), int'(c_et && (m_q.size() == 0)));
         check("model_pdm", int'(pdm_out), int'(m_pdm));
         check("model_cur", int'(dut.cur), m_cur);
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      bit v;
      int d;
      bit rdy;
      bit tk;
      bit un;
      bit pdm;
   } vec_t;

   vec_t tbl[16];

   task automatic wait_tick(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * OSRP && !seen; i++) begin
         if (tick) seen = 1'b1;
         else @(negedge clk);
      end
      check({name, "_tick_seen"}, int'(seen), 1);
   endtask

   int ones;
   int und_cnt;
   int xfer_cnt;
   bit xfer_now;
   int val;

   initial begin
      // row k: inputs applied and outputs checked k clocks after reset release
      tbl = '{
         '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 1, 1, 0},
         '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 1, 1, 0},
         '{1, 0, 1, 0, 0, 1}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 1}, '{0, 0, 1, 1, 0, 0},
         '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 1, 1, 0}
      };

      rst      = 1'b1;
      in_valid = 1'b0;
      din      = '0;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_ready", int'(in_ready), 1);
      check("rst_tick", int'(tick), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_pdm", int'(pdm_out), 0);
      check("rst_cur", int'(dut.cur), MID);

      rst    = 1'b0;
      chk_en = 1'b1;

      // mid-scale start-up, underrun on ticks, first push of 0
      for (int k = 0; k < 16; k++) begin
         in_valid = tbl[k].v;
         din      = BD'(tbl[k].d);
         check($sformatf("tbl%0d_ready", k), int'(in_ready), int'(tbl[k].rdy));
         check($sformatf("tbl%0d_tick", k), int'(tick), int'(tbl[k].tk));
         check($sformatf("tbl%0d_underrun", k), int'(underrun), int'(tbl[k].un));
         check($sformatf("tbl%0d_pdm", k), int'(pdm_out), int'(tbl[k].pdm));
         @(negedge clk);
      end
      in_valid = 1'b0;

      // input 0 held: silence on the pin, underrun on every tick
      und_cnt = 0;
      ones    = 0;
      for (int i = 0; i < 64; i++) begin
         ones    += int'(pdm_out);
         und_cnt += int'(underrun);
         @(negedge clk);
      end
      check("zero_ones_64", ones, 0);
      check("zero_underruns_64", und_cnt, 64 / OSRP);

      // full scale: exactly one zero per 2^BITDEPTH clocks
      check("fs_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      din      = BD'(FULL - 1);
      @(negedge clk);
      in_valid = 1'b0;
      wait_tick("fs");
      @(negedge clk);
      check("fs_latency_pdm", int'(pdm_out), 0);
      ones = 0;
      for (int i = 0; i < FULL; i++) begin
         @(negedge clk);
         ones += int'(pdm_out);
      end
      check("fs_ones_16384", ones, FULL - 1);

      // streaming producer: one transfer per OSR clocks, no underrun
      val      = 100;
      din      = BD'(val);
      in_valid = 1'b1;
      xfer_cnt = 0;
      und_cnt  = 0;
      for (int c = 0; c < 48; c++) begin
         xfer_now = in_valid && in_ready;
         if (c >= 8) begin
            xfer_cnt += int'(xfer_now);
            und_cnt  += int'(underrun);
         end
         @(negedge clk);
         if (xfer_now) begin
            val++;
            din = BD'(val);
         end
      end
      check("stream_xfers_40", xfer_cnt, 40 / OSRP);
      check("stream_underruns", und_cnt, 0);

      // fill pend on a tick, then reset before it can be promoted
      wait_tick("prerst");
      @(negedge clk);
      in_valid = 1'b0;
      check("prerst_pend_full", int'(in_ready), 0);
      rst = 1'b1;
      #1;
      check("midrst_ready", int'(in_ready), 1);
      check("midrst_tick", int'(tick), 0);
      check("midrst_underrun", int'(underrun), 0);
      check("midrst_pdm", int'(pdm_out), 0);
      check("midrst_cur", int'(dut.cur), MID);
      @(negedge clk);
      rst = 1'b0;
      und_cnt = 0;
      for (int i = 0; i < 3 * OSRP; i++) begin
         check("postrst_cur", int'(dut.cur), MID);
         und_cnt += int'(underrun);
         @(negedge clk);
      end
      check("postrst_underruns", und_cnt, 3);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 7))
            0:       din = '0;
            1:       din = '1;
            default: din = BD'($urandom);
         endcase
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_pdm_dac.md
# audio_pdm_dac

Final audio output stage: accepts offset-binary samples from the volume amplifier over a valid/ready handshake and converts them to a 1-bit pulse-density stream on the speaker pin using a first-order delta-sigma modulator clocked at the system clock. A one-entry pending register decouples the producer from the output sample rate, which is set by an oversampling divider. Idles at mid-scale, matching the amplifier's silent level.

## Interface
- BITDEPTH, 14, sample width; offset-binary, mid-scale 2^(BITDEPTH-1) = silence
- OSR, 1024, system clocks per output sample; legal range 2..65536
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in  in  BITDEPTH  sample from amplifier stage
- in_valid  in  1  `in` holds a sample
- in_ready  out  1  block accepts `in` this cycle
- pdm_out  out  1  registered pulse-density output to pin
- underrun  out  1  one-cycle pulse: sample tick with no pending sample
- tick  out  1  one-cycle pulse on each output-sample boundary

## Operation
- Divider `div_cnt` counts 0..OSR-1 and wraps; `tick` = (div_cnt == OSR-1).
- Pending register `pend`/`pend_valid`; `in_ready = !pend_valid || tick`.
- Transfer occurs when `in_valid && in_ready`: `pend <= in`, `pend_valid <= 1`.
- On `tick`: if `pend_valid`, `cur <= pend` and `pend_valid` clears, unless a transfer occurs in the same cycle, in which case the new sample loads `pend` and `pend_valid` stays 1. If `!pend_valid`, `cur` holds its last value and `underrun` pulses.
- Modulator, every clk: `sum = {1'b0, acc} + eff` (BITDEPTH+1 bits); `acc <= sum[BITDEPTH-1:0]`; `pdm_out <= sum[BITDEPTH]`.
- `eff = cur` when dither is disabled (see Configuration).
- Ones-density of `pdm_out` = eff / 2^BITDEPTH; input 0 gives constant 0; input 2^BITDEPTH-1 gives exactly one 0 per 2^BITDEPTH clocks.
- Accumulator wraps naturally. No saturation is needed because `eff` ≤ 2^BITDEPTH-1.

## Timing
- Reset values: div_cnt=0, pend_valid=0, pend=0, cur=2^(BITDEPTH-1), acc=0, pdm_out=0, underrun=0, tick=0; in_ready=1.
- Accepted sample reaches `cur` on the next `tick` edge. It affects `pdm_out` one clk after that edge.
- Worst-case latency from acceptance to output effect: OSR+1 clks.
- Throughput: one sample per OSR clks. A producer holding `in_valid` high sees `in_ready` low except on `tick` cycles once `pend` is full.
- Mid-scale from reset, BITDEPTH=14: pdm_out sequence after reset deassert is 0,0,1,0,1,0,1,…
  - The first 0 is the reset value.
  - acc goes 0 → 8192 (no carry), then 8192 → 0 (carry).
- Reset asserted mid-stream clears state asynchronously, discards `pend`, and restarts at mid-scale. No `underrun` is generated during reset.
- `tick` and `underrun` are combinational from registered state, or registered with matching one-cycle alignment. Either way, `underrun` must coincide with `tick`.

## Configuration
- `AUDIO_PDM_DITHER_EN` defined:
  - 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every clk.
  - `eff = cur + 1` when lfsr[0]=1, else `cur - 1`.
  - Result is clamped to [0, 2^BITDEPTH-1].
  - Breaks idle tones on constant inputs.
- Not defined: no LFSR logic is present and `eff = cur` exactly.
- Test expectations below assume the macro is undefined unless noted.

## Test plan
- Reset, no input, BITDEPTH=14, OSR=4 → in_ready=1; pdm_out 0,0,1,0,1…; `underrun` pulses on every `tick` (every 4th clk).
- Push in=0 then hold in_valid=0 → after the next tick, pdm_out stays 0 for ≥64 clks; underrun pulses on each subsequent tick.
- Push in=16383, count pdm_out over 16384 clks after it loads → exactly 16383 ones.
- Producer holds in_valid=1 with incrementing samples, OSR=4 → exactly one transfer per 4 clks after the first two; no underrun; samples reach `cur` in order with no loss or duplication.
- Assert rst for 1 clk mid-stream with pend_valid=1 → all outputs return to reset values; the pending sample never appears on `cur`.
- With `AUDIO_PDM_DITHER_EN`, in=0 held → eff is never below 0 (clamped); ones-density over 65536 clks is between 0 and 2/16384.
